// File: rtl/note_lookup_bsearch.sv
// FFT peak bin to note index mapper using a fixed-latency binary search over a floor table.
// Define NOTE_LOOKUP_TBL_WR_EN to make the table writable at run time.
module note_lookup_bsearch #(
    parameter int unsigned BIN_WIDTH   = 13,
    parameter int unsigned NUM_NOTES   = 22,
    parameter int unsigned FLOOR_WIDTH = 10,
    parameter int unsigned NOTE_WIDTH  = 6,
    parameter int unsigned BASE_NOTE   = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [BIN_WIDTH-1:0]         bin_index_in,
    input  logic                         bin_valid_in,
    output logic                         bin_ready_out,
    output logic [NOTE_WIDTH-1:0]        note_index_out,
    output logic                         miss_out,
    output logic                         note_valid_out,
    input  logic                         note_ready_in,
    input  logic                         tbl_we_in,
    input  logic [$clog2(NUM_NOTES)-1:0] tbl_addr_in,
    input  logic [FLOOR_WIDTH-1:0]       tbl_data_in
);

    localparam int unsigned PosW  = $clog2(NUM_NOTES + 1);
    localparam int unsigned Steps = $clog2(NUM_NOTES + 1);
    localparam int unsigned IterW = $clog2(Steps + 1);
    localparam int unsigned CmpW  = (BIN_WIDTH > FLOOR_WIDTH) ? BIN_WIDTH : FLOOR_WIDTH;

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    function automatic logic [FLOOR_WIDTH-1:0] default_floor(input int unsigned idx);
        logic [FLOOR_WIDTH-1:0] f;
        case (idx)
            0:  f = FLOOR_WIDTH'(63);
            1:  f = FLOOR_WIDTH'(66);
            2:  f = FLOOR_WIDTH'(70);
            3:  f = FLOOR_WIDTH'(74);
            4:  f = FLOOR_WIDTH'(79);
            5:  f = FLOOR_WIDTH'(84);
            6:  f = FLOOR_WIDTH'(89);
            7:  f = FLOOR_WIDTH'(94);
            8:  f = FLOOR_WIDTH'(100);
            9:  f = FLOOR_WIDTH'(106);
            10: f = FLOOR_WIDTH'(112);
            11: f = FLOOR_WIDTH'(119);
            12: f = FLOOR_WIDTH'(126);
            13: f = FLOOR_WIDTH'(133);
            14: f = FLOOR_WIDTH'(141);
            15: f = FLOOR_WIDTH'(149);
            16: f = FLOOR_WIDTH'(158);
            17: f = FLOOR_WIDTH'(168);
            18: f = FLOOR_WIDTH'(178);
            19: f = FLOOR_WIDTH'(188);
            20: f = FLOOR_WIDTH'(200);
            21: f = FLOOR_WIDTH'(212);
            default: f = '1;
        endcase
        return f;
    endfunction

    state_e                 state_q;
    logic [BIN_WIDTH-1:0]   bin_q;
    logic [PosW-1:0]        lo_q, hi_q;
    logic [IterW-1:0]       iter_q;
    logic [FLOOR_WIDTH-1:0] tbl [NUM_NOTES];

`ifdef NOTE_LOOKUP_TBL_WR_EN
    logic tbl_wr;
    assign tbl_wr        = (state_q == StIdle) && tbl_we_in && (32'(tbl_addr_in) < NUM_NOTES);
    assign bin_ready_out = (state_q == StIdle) && !tbl_we_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_NOTES; i++) tbl[i] <= default_floor(i);
        end else if (tbl_wr) begin
            tbl[tbl_addr_in] <= tbl_data_in;
        end
    end
`else
    logic unused_tbl_port;
    assign unused_tbl_port = ^{tbl_we_in, tbl_addr_in, tbl_data_in};
    assign bin_ready_out   = (state_q == StIdle);

    always_comb begin
        for (int unsigned i = 0; i < NUM_NOTES; i++) tbl[i] = default_floor(i);
    end
`endif

    logic [PosW:0]      mid_sum;
    logic [PosW-1:0]    mid, lo_step, hi_step;
    logic [CmpW-1:0]    mid_floor, bin_cmp;

    // mid can equal NUM_NOTES once the range has collapsed; the mux keeps that read in range.
    always_comb begin
        mid_sum   = {1'b0, lo_q} + {1'b0, hi_q};
        mid       = mid_sum[PosW:1];
        mid_floor = '1;
        for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            if (PosW'(i) == mid) mid_floor = CmpW'(tbl[i]);
        end
        bin_cmp = CmpW'(bin_q);
        lo_step = lo_q;
        hi_step = hi_q;
        if (lo_q < hi_q) begin
            if (mid_floor >= bin_cmp) hi_step = mid;
            else                      lo_step = mid + PosW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= StIdle;
            bin_q          <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            iter_q         <= '0;
            note_index_out <= '0;
            miss_out       <= 1'b0;
            note_valid_out <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bin_valid_in && bin_ready_out) begin
                        bin_q   <= bin_index_in;
                        lo_q    <= '0;
                        hi_q    <= PosW'(NUM_NOTES);
                        iter_q  <= '0;
                        state_q <= StSearch;
                    end
                end
                StSearch: begin
                    lo_q   <= lo_step;
                    hi_q   <= hi_step;
                    iter_q <= iter_q + IterW'(1);
                    if (iter_q == IterW'(Steps - 1)) begin
                        state_q        <= StDone;
                        note_valid_out <= 1'b1;
                        if (lo_step == PosW'(NUM_NOTES)) begin
                            miss_out       <= 1'b1;
                            note_index_out <= '0;
                        end else begin
                            miss_out       <= 1'b0;
                            note_index_out <= NOTE_WIDTH'(BASE_NOTE) + NOTE_WIDTH'(lo_step);
                        end
                    end
                end
                StDone: begin
                    if (note_ready_in) begin
                        note_valid_out <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_note_lookup_bsearch.sv
// Directed bench for note_lookup_bsearch: latency, table hits/misses, backpressure,
// table write behaviour (either build) and mid-search reset.
module tb_note_lookup_bsearch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] bin_index;
    logic        bin_valid;
    logic        bin_ready;
    logic [5:0]  note_index;
    logic        miss;
    logic        note_valid;
    logic        note_ready;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [9:0]  tbl_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    note_lookup_bsearch dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .bin_index_in   (bin_index),
        .bin_valid_in   (bin_valid),
        .bin_ready_out  (bin_ready),
        .note_index_out (note_index),
        .miss_out       (miss),
        .note_valid_out (note_valid),
        .note_ready_in  (note_ready),
        .tbl_we_in      (tbl_we),
        .tbl_addr_in    (tbl_addr),
        .tbl_data_in    (tbl_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one bin, wait (bounded) for the result, check latency/value, then handshake.
    task automatic lookup(input string tag, input int bin, input int exp_note, input int exp_miss);
        int lat;
        bin_index = 13'(bin);
        bin_valid = 1'b1;
        check({tag, ":ready"}, 32'(bin_ready), 1);
        tick;
        bin_valid = 1'b0;
        bin_index = 13'($urandom);
        lat = 0;
        while (!note_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, ":latency"}, lat, 5);
        check({tag, ":note"}, 32'(note_index), exp_note);
        check({tag, ":miss"}, 32'(miss), exp_miss);
        tick;
        check({tag, ":valid_drop"}, 32'(note_valid), 0);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n      = 1'b0;
        bin_index  = '0;
        bin_valid  = 1'b0;
        note_ready = 1'b1;
        tbl_we     = 1'b0;
        tbl_addr   = '0;
        tbl_data   = '0;
        #2;
        check("rst_ready", 32'(bin_ready), 1);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_miss", 32'(miss), 0);
        check("rst_note", 32'(note_index), 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        lookup("bin100", 100, 40, 0);
        lookup("bin0", 0, 32, 0);
        lookup("bin63", 63, 32, 0);
        lookup("bin64", 64, 33, 0);
        lookup("bin212", 212, 53, 0);
        lookup("bin213", 213, 0, 1);
        lookup("bin8191", 8191, 0, 1);

        // Backpressure: result held for 10 cycles with note_ready low.
        note_ready = 1'b0;
        bin_index  = 13'd150;
        bin_valid  = 1'b1;
        tick;
        bin_valid = 1'b0;
        lat = 0;
        while (!note_valid && lat < 20) begin
            tick;
            lat++;
        end
        check("bp:latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            check("bp:note", 32'(note_index), 48);
            check("bp:valid", 32'(note_valid), 1);
            check("bp:ready", 32'(bin_ready), 0);
            tick;
        end
        note_ready = 1'b1;
        tick;
        check("bp:valid_after", 32'(note_valid), 0);
        check("bp:ready_after", 32'(bin_ready), 1);

`ifdef NOTE_LOOKUP_TBL_WR_EN
        // Write during SEARCH is dropped: entry 8 stays 100, so bin 101 maps to 41.
        bin_index = 13'd101;
        bin_valid = 1'b1;
        tick;
        bin_valid = 1'b0;
        tbl_we    = 1'b1;
        tbl_addr  = 5'd8;
        tbl_data  = 10'd101;
        tick;
        tbl_we = 1'b0;
        lat = 0;
        while (!note_valid && lat < 20) begin
            tick;
            lat++;
        end
        check("wrsearch:note", 32'(note_index), 41);
        tick;
        lookup("wrsearch_after", 101, 41, 0);

        // Write and bin in the same IDLE cycle: write wins, bin dropped.
        tbl_we    = 1'b1;
        tbl_addr  = 5'd8;
        tbl_data  = 10'd101;
        bin_index = 13'd100;
        bin_valid = 1'b1;
        #1;
        check("wrcoll:ready", 32'(bin_ready), 0);
        tick;
        tbl_we    = 1'b0;
        bin_valid = 1'b0;
        check("wrcoll:ready_after", 32'(bin_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (note_valid) seen = 1'b1;
            tick;
        end
        check("wrcoll:no_result", 32'(seen), 0);
        lookup("wr_bin101", 101, 40, 0);
`else
        // Without the write port, strobes are ignored and the table stays at defaults.
        tbl_we   = 1'b1;
        tbl_addr = 5'd8;
        tbl_data = 10'd101;
        #1;
        check("nowr:ready", 32'(bin_ready), 1);
        tick;
        lookup("nowr_bin101", 101, 41, 0);
        tbl_we = 1'b0;
`endif

        // Reset two cycles after accepting bin 150.
        bin_index = 13'd150;
        bin_valid = 1'b1;
        tick;
        bin_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("rstmid:valid", 32'(note_valid), 0);
        check("rstmid:miss", 32'(miss), 0);
        check("rstmid:note", 32'(note_index), 0);
        check("rstmid:ready", 32'(bin_ready), 1);
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (note_valid) seen = 1'b1;
            tick;
        end
        check("rstmid:no_result", 32'(seen), 0);
        lookup("post_rst_bin100", 100, 40, 0);
        lookup("post_rst_bin101", 101, 41, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
